// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional 2-entry skid buffer and flush
module pipe_stage_reg #(
    parameter int DATA_W     = 153,
    parameter int SKID       = 0,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    localparam bit CLR = CLEAR_DATA != 0;
    logic in_fire, out_fire;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    if (SKID == 0) begin : g_reg
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data_q, data_d;
        // Flush wins, a new payload wins over draining, a drain without refill leaves a bubble
        always_comb begin
            valid_d = flush ? 1'b0 : in_fire ? 1'b1 : out_fire ? 1'b0 : valid_q;
            data_d  = (flush || (out_fire && !in_fire)) ? (CLR ? '0 : data_q) : in_fire ? in_data : data_q;
        end
        // Stage register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
        assign in_ready  = out_ready | ~valid_q;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign count     = {1'b0, valid_q};
    end else begin : g_skid
        typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
        state_e            state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
        logic              ready_q;
        // State and data registers; ready is registered so it never depends on out_ready
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= state_d != FULL;
            end
        end
        // Next state: main always holds the oldest entry, skid the younger one
        always_comb begin
            state_d = state_q;
            case (state_q)
                EMPTY:   state_d = in_fire ? ONE : EMPTY;
                ONE:     state_d = (in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE;
                default: state_d = out_fire ? ONE : FULL;
            endcase
            if (flush) state_d = EMPTY;
            main_d = flush ? (CLR ? '0 : main_q)
                   : (in_fire && (state_q == EMPTY || out_fire)) ? in_data
                   : (out_fire && state_q == FULL) ? skid_q
                   : out_fire ? (CLR ? '0 : main_q) : main_q;
            skid_d = flush ? (CLR ? '0 : skid_q)
                   : (in_fire && !out_fire && state_q == ONE) ? in_data
                   : (out_fire && state_q == FULL) ? '0 : skid_q;
        end
        // Outputs decode straight from registers
        always_comb begin
            in_ready  = ready_q;
            out_valid = state_q != EMPTY;
            out_data  = main_q;
            count     = state_q;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench over all SKID/CLEAR_DATA combinations against a FIFO model
module tb_pipe_stage_reg;
    localparam int DW = 16;
    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    rdy, ov;
    logic [1:0]    cnt [4];
    logic [DW-1:0] od  [4];
    int            errs = 0, checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, g, act, exp, $time);
        end
    endtask

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int SK = i % 2;
        localparam int CL = (i < 2) ? 1 : 0;
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] last = '0;
        logic          acc_ok = 1'b0;
        logic          er;
        int            n;
        pipe_stage_reg #(.DATA_W(DW), .SKID(SK), .CLEAR_DATA(CL)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(in_valid), .in_ready(rdy[i]), .in_data(in_data),
            .out_valid(ov[i]), .out_ready(out_ready), .out_data(od[i]), .count(cnt[i])
        );
        // Stimulus side: a payload the model deems accepted is queued at the edge
        always @(posedge clk)
            if (rst_n && in_valid && !flush && acc_ok) exp_q.push_back(in_data);
        // Monitor: compare against the queue, pop on consumption, drop everything on flush
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                last   = '0;
                acc_ok = 1'b0;
            end else begin
                n  = exp_q.size();
                er = (SK != 0) ? (n < 2) : (out_ready || n == 0);
                chk("in_ready", i, 32'(rdy[i]), 32'(er));
                chk("out_valid", i, 32'(ov[i]), 32'(n > 0));
                chk("count", i, 32'(cnt[i]), 32'(n));
                if (n > 0) last = exp_q[0];
                chk("out_data", i, 32'(od[i]), 32'((n > 0 || CL == 0) ? last : '0));
                acc_ok = er;
                if (n > 0 && out_ready) void'(exp_q.pop_front());
                if (flush) exp_q.delete();
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("rst_valid", g, 32'(ov[g]), 32'(0));
            chk("rst_count", g, 32'(cnt[g]), 32'(0));
            chk("rst_data", g, 32'(od[g]), 32'(0));
        end
        rst_n = 1'b1;
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 16'h1, 1'b1, 1'b0);
        step(1'b1, 16'h2, 1'b1, 1'b0);
        step(1'b1, 16'h3, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hA, 1'b0, 1'b0);
        step(1'b1, 16'hB, 1'b0, 1'b0);
        step(1'b1, 16'hC, 1'b0, 1'b0);
        repeat (2) step(1'b1, 16'hC, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hA, 1'b0, 1'b0);
        step(1'b1, 16'hB, 1'b0, 1'b0);
        step(1'b1, 16'hD, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h55, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        repeat (3000)
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        step(1'b1, 16'h11, 1'b0, 1'b0);
        step(1'b1, 16'h22, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("async_rst_valid", g, 32'(ov[g]), 32'(0));
            chk("async_rst_count", g, 32'(cnt[g]), 32'(0));
            chk("async_rst_ready", g, 32'(rdy[g]), 32'(1));
        end
        #3;
        rst_n = 1'b1;
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h77, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the successor to the fixed-field stage latches between op-read and execute.
- Carries one opaque payload bus of DATA_W bits with a valid/ready handshake instead of a bare enable.
- Supports a synchronous flush that inserts a bubble.
- Optional 2-entry skid mode registers in_ready so backpressure does not form a long combinational path through the pipeline.

Parameters:
DATA_W, 153, payload width in bits (imm+rd+rs1_data+rs2_data+pc+funct3+flags of the op-read stage).
SKID, 0, 0 = single register with pass-through ready; 1 = 2-entry skid buffer with registered ready.
CLEAR_DATA, 1, 1 = out_data forced to 0 whenever out_valid is 0 (bubble is all-zero); 0 = data held.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all held entries.
in_valid  input  1  upstream has payload.
in_ready  output  1  stage accepts payload this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data holds a live payload.
out_ready  input  1  downstream consumes this cycle.
out_data  output  DATA_W  payload to next stage.
count  output  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).

Behaviour:
- Reset (rst_n low, async, regardless of clk): out_valid=0, out_data=0, count=0, skid entry invalid and zero. After reset, in_ready=1 in both modes.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - The payload is sampled only on in_fire.
  - in_data is don't-care when in_valid=0.
  - out_valid never drops without out_fire or flush.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle in both modes; data accepted at edge N is presented on out_data after edge N.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - in_fire: out_data<=in_data, out_valid<=1.
  - out_fire without in_fire: out_valid<=0; out_data<=0 if CLEAR_DATA, else held.
  - Simultaneous in_fire and out_fire: back-to-back, 1 transfer/cycle.
- SKID=1: states EMPTY (count 0), ONE (count 1), FULL (count 2). in_ready = (state != FULL), registered, no combinational dependence on out_ready.
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire only -> FULL, skid<=in_data. out_fire only -> EMPTY.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid, skid cleared.
  - out_valid = (state != EMPTY); out_data = main register.
  - Ordering: strictly FIFO; skid entry is never bypassed.
  - Sustained throughput is 1/cycle when out_ready stays high.
- Flush (both modes):
  - Highest priority over in_fire and out_fire in the same cycle.
  - Next state EMPTY, count 0, out_valid 0, all data zero if CLEAR_DATA.
  - Payload offered in the flush cycle is dropped, even if in_ready was 1.
  - An out_fire in the flush cycle still counts as consumed downstream (downstream sampled it).
- count = number of valid entries, updated with state.
- Mid-operation reset: all entries lost immediately; no partial payload is ever presented.

Test Plan:
- Reset then idle, both SKID values: out_valid=0, out_data=0, count=0, in_ready=1 on first edge after rst_n rises.
- SKID=0, out_ready=1, stream in_data=1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, no gaps, in_ready constantly 1.
- SKID=1, out_ready=0, offer 0xA, 0xB, 0xC on 3 cycles:
  - 0xA and 0xB are accepted; count reaches 2; in_ready=0 on cycle 3, so 0xC is held upstream.
  - Raising out_ready gives out_data 0xA, 0xB, 0xC in order.
- SKID=1, flush asserted with count=2 and in_valid=1 (0xD) -> next cycle count=0, out_valid=0, out_data=0, in_ready=1; 0xD never appears.
- SKID=0, CLEAR_DATA=0, single transfer 0x55 then out_fire -> out_valid=0, out_data stays 0x55. With CLEAR_DATA=1 -> out_data=0.
- rst_n pulsed low mid-stream between edges (count=2) -> out_valid/count drop to 0 immediately without a clock edge.
